// File: rtl/easyaxi_rd_arb_if.sv
// easyaxi_rd_arb_if -- AXI read-address / read-data bundle.
//
// One instance carries N parallel AR/R ports. Per-port fields are packed
// with port i at bits [(i+1)*W-1 : i*W]. R payload (rdata/rresp/rlast) is a
// single shared copy, so it is broadcast to every port of the bundle.
//
// Modports:
//   master : drives arvalid, ar payload, rready; receives arready, rvalid, R payload
//   slave  : the mirror image of master
//
// Field widths come from the global `AXI_*_W defines; defaults are supplied
// here if the including build has not set them.
//
// Valid/ready semantics: a transfer happens on a rising clk edge where both
// valid and ready are high; valid does not wait for ready, and the payload is
// held stable while valid is high and ready is low.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

interface easyaxi_rd_arb_if #(
  parameter int N = 1
);
  logic [N-1:0]                arvalid;
  logic [N-1:0]                arready;
  logic [N*`AXI_ID_W-1:0]      arid;
  logic [N*`AXI_ADDR_W-1:0]    araddr;
  logic [N*`AXI_LEN_W-1:0]     arlen;
  logic [N*`AXI_SIZE_W-1:0]    arsize;
  logic [N*`AXI_BURST_W-1:0]   arburst;
  logic [N-1:0]                rvalid;
  logic [N-1:0]                rready;
  logic [`AXI_DATA_W-1:0]      rdata;
  logic [`AXI_RESP_W-1:0]      rresp;
  logic                        rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb -- two-master AXI read arbiter, one transaction in flight.
//
// An IDLE -> ADDR -> DATA FSM grants one upstream master, forwards its AR
// request downstream, routes the R beats back to it until rlast, then
// returns to IDLE. Ties go round-robin against the last completed grant.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       low blocks new grants; an in-flight transaction completes
//   axi_m        upstream bundle (N = NUM_MST), slave modport
//   axi_s        downstream bundle (N = 1), master modport
//   arb_grant    one-hot grant, zero in IDLE
//   arb_busy     high whenever the FSM is not in IDLE
//   arb_state    current FSM state (IDLE=0, ADDR=1, DATA=2)
//
// Build option: define EASYAXI_RD_ARB_FIXED_PRI_EN to make master 0 win
// every tie (no round-robin history kept).
//
// Only NUM_MST = 2 is supported.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_arb #(
  parameter int NUM_MST = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  easyaxi_rd_arb_if.slave      axi_m,
  easyaxi_rd_arb_if.master     axi_s,
  output logic [NUM_MST-1:0]   arb_grant,
  output logic                 arb_busy,
  output logic [1:0]           arb_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] state;
  logic [1:0] grant;
  logic [1:0] winner;
  logic       gidx;
  logic       ar_hs;
  logic       r_done;

`ifdef EASYAXI_RD_ARB_FIXED_PRI_EN
  always_comb begin
    winner = 2'b00;
    if (axi_m.arvalid[0])      winner = 2'b01;
    else if (axi_m.arvalid[1]) winner = 2'b10;
  end
`else
  // One-hot grant of the last completed transaction; resets to master 1 so
  // master 0 wins the first tie.
  logic [1:0] last_grant;

  always_comb begin
    // A lone requester (or none) is its own winner.
    winner = axi_m.arvalid;
    if (axi_m.arvalid == 2'b11) winner = last_grant[0] ? 2'b10 : 2'b01;
  end
`endif

  assign gidx = grant[1];

  // Downstream AR: only the granted master's valid, and only in ADDR.
  assign axi_s.arvalid = (state == ADDR) && ((axi_m.arvalid & grant) != 2'b00);
  assign axi_s.arid    = gidx ? axi_m.arid[2*`AXI_ID_W-1:`AXI_ID_W]
                              : axi_m.arid[`AXI_ID_W-1:0];
  assign axi_s.araddr  = gidx ? axi_m.araddr[2*`AXI_ADDR_W-1:`AXI_ADDR_W]
                              : axi_m.araddr[`AXI_ADDR_W-1:0];
  assign axi_s.arlen   = gidx ? axi_m.arlen[2*`AXI_LEN_W-1:`AXI_LEN_W]
                              : axi_m.arlen[`AXI_LEN_W-1:0];
  assign axi_s.arsize  = gidx ? axi_m.arsize[2*`AXI_SIZE_W-1:`AXI_SIZE_W]
                              : axi_m.arsize[`AXI_SIZE_W-1:0];
  assign axi_s.arburst = gidx ? axi_m.arburst[2*`AXI_BURST_W-1:`AXI_BURST_W]
                              : axi_m.arburst[`AXI_BURST_W-1:0];

  // Upstream ready/valid are masked by grant, so non-granted masters see 0.
  assign axi_m.arready = (state == ADDR && axi_s.arready) ? grant : 2'b00;
  assign axi_m.rvalid  = (state == DATA && axi_s.rvalid)  ? grant : 2'b00;
  assign axi_s.rready  = (state == DATA) && ((axi_m.rready & grant) != 2'b00);

  // R payload is broadcast; rvalid alone selects the receiver.
  assign axi_m.rdata = axi_s.rdata;
  assign axi_m.rresp = axi_s.rresp;
  assign axi_m.rlast = axi_s.rlast;

  assign ar_hs  = axi_s.arvalid & axi_s.arready;
  assign r_done = axi_s.rvalid & axi_s.rready & axi_s.rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= 2'b00;
    end else begin
      case (state)
        IDLE: if (enable && winner != 2'b00) begin
          grant <= winner;
          state <= ADDR;
        end
        // A dropped arvalid simply keeps us here with the grant held.
        ADDR: if (ar_hs) state <= DATA;
        DATA: if (r_done) begin
          grant <= 2'b00;
          state <= IDLE;
        end
        default: begin
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef EASYAXI_RD_ARB_FIXED_PRI_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      last_grant <= 2'b10;
    else if (state == DATA && r_done) last_grant <= grant;
  end
`endif

  assign arb_grant = grant;
  assign arb_busy  = (state != IDLE);
  assign arb_state = state;

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
module tb_easyaxi_rd_arb;

  logic clk;
  logic rst_n;
  logic enable;
  logic [1:0] arb_grant;
  logic       arb_busy;
  logic [1:0] arb_state;

  easyaxi_rd_arb_if #(.N(2)) m_bus ();
  easyaxi_rd_arb_if #(.N(1)) s_bus ();

  easyaxi_rd_arb #(.NUM_MST(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .axi_m     (m_bus),
    .axi_s     (s_bus),
    .arb_grant (arb_grant),
    .arb_busy  (arb_busy),
    .arb_state (arb_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [`AXI_DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       en;
    logic [1:0] arv;
    logic       s_arr;
    logic       s_rv;
    logic       s_rl;
    logic [1:0] m_rr;
    logic [1:0] resp;
    logic       e_s_arv;
    logic [1:0] e_arr;
    logic [1:0] e_rv;
    logic       e_s_rr;
    logic [1:0] e_grant;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic [1:0] arv, input logic s_arr,
                              input logic s_rv, input logic s_rl, input logic [1:0] m_rr,
                              input logic [1:0] resp, input logic e_s_arv, input logic [1:0] e_arr,
                              input logic [1:0] e_rv, input logic e_s_rr, input logic [1:0] e_grant,
                              input logic e_busy);
    vec_t v;
    v.en = en; v.arv = arv; v.s_arr = s_arr; v.s_rv = s_rv; v.s_rl = s_rl;
    v.m_rr = m_rr; v.resp = resp; v.e_s_arv = e_s_arv; v.e_arr = e_arr;
    v.e_rv = e_rv; v.e_s_rr = e_s_rr; v.e_grant = e_grant; v.e_busy = e_busy;
    return v;
  endfunction

  // ---------------- driver helpers ----------------
  task automatic idle_inputs();
    enable         = 1'b1;
    m_bus.arvalid  = 2'b00;
    m_bus.rready   = 2'b00;
    s_bus.arready  = 1'b0;
    s_bus.rvalid   = 1'b0;
    s_bus.rlast    = 1'b0;
    s_bus.rresp    = '0;
    s_bus.rdata    = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_arvalid"}, s_bus.arvalid, 1'b0);
    chk({tag, "_s_rready"},  s_bus.rready,  1'b0);
    chk({tag, "_m_arready"}, m_bus.arready, 2'b00);
    chk({tag, "_m_rvalid"},  m_bus.rvalid,  2'b00);
    chk({tag, "_grant"},     arb_grant,     2'b00);
    chk({tag, "_busy"},      arb_busy,      1'b0);
  endtask

  // One complete read by master mst, starting in IDLE with no competitor.
  // The beat at index stall_beat is held off by rready for stall_n cycles.
  task automatic do_read(input int mst, input logic [7:0] len, input logic [1:0] resp,
                         input int stall_beat, input int stall_n,
                         input logic [31:0] exp_addr, input logic [3:0] exp_id,
                         input logic [2:0] exp_size, input logic [1:0] exp_burst);
    logic [1:0] g;
    int oth;
    g   = 2'b01 << mst;
    oth = 1 - mst;
    m_bus.arlen[mst*8 +: 8] = len;
    m_bus.arvalid[mst] = 1'b1;
    #3;
    chk("rd_idle_s_arvalid", s_bus.arvalid, 1'b0);
    next_cycle();
    chk("rd_addr_s_arvalid", s_bus.arvalid, 1'b1);
    chk("rd_addr_grant",     arb_grant, g);
    chk("rd_addr_araddr",    s_bus.araddr, exp_addr);
    chk("rd_addr_arid",      s_bus.arid, exp_id);
    chk("rd_addr_arlen",     s_bus.arlen, len);
    chk("rd_addr_arsize",    s_bus.arsize, exp_size);
    chk("rd_addr_arburst",   s_bus.arburst, exp_burst);
    s_bus.arready = 1'b1;
    #3;
    chk("rd_addr_m_arready", m_bus.arready, g);
    next_cycle();
    s_bus.arready = 1'b0;
    m_bus.arvalid[mst] = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_bus.rdata  = $urandom;
      s_bus.rvalid = 1'b1;
      s_bus.rlast  = (b == int'(len));
      s_bus.rresp  = resp;
      exp_q.push_back(s_bus.rdata);
      if (b == stall_beat) begin
        m_bus.rready[mst] = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          #3;
          chk("stall_s_rready", s_bus.rready, 1'b0);
          chk("stall_m_rvalid", m_bus.rvalid, g);
          chk("stall_rdata",    m_bus.rdata, exp_q[0]);
          next_cycle();
        end
      end
      m_bus.rready[mst] = 1'b1;
      #3;
      chk("beat_m_rvalid",  m_bus.rvalid[mst], 1'b1);
      chk("beat_oth_rvalid", m_bus.rvalid[oth], 1'b0);
      chk("beat_s_rready",  s_bus.rready, 1'b1);
      chk("beat_rresp",     m_bus.rresp, resp);
      chk("beat_rlast",     m_bus.rlast, (b == int'(len)));
      chk("beat_rdata",     m_bus.rdata, exp_q.pop_front());
      chk("beat_busy",      arb_busy, 1'b1);
      next_cycle();
    end
    s_bus.rvalid = 1'b0;
    s_bus.rlast  = 1'b0;
    m_bus.rready[mst] = 1'b0;
    #3;
    chk("rd_end_busy",  arb_busy, 1'b0);
    chk("rd_end_grant", arb_grant, 2'b00);
    chk("rd_end_queue", exp_q.size(), 0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [1:0] g2;
`ifdef EASYAXI_RD_ARB_FIXED_PRI_EN
    g2 = 2'b01;
`else
    g2 = 2'b10;
`endif
    // Tie sequence (arlen 0), enable low with both requesting, arvalid dropped
    // in ADDR, enable dropped during ADDR/DATA.
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  0, 2'b00, 2'b00, 0, 2'b00, 0));
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  1, 2'b01, 2'b00, 0, 2'b01, 1));
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  0, 2'b00, 2'b01, 1, 2'b01, 1));
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  0, 2'b00, 2'b00, 0, 2'b00, 0));
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  1, g2,    2'b00, 0, g2,    1));
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  0, 2'b00, g2,    1, g2,    1));
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  0, 2'b00, 2'b00, 0, 2'b00, 0));
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  1, 2'b01, 2'b00, 0, 2'b01, 1));
    tbl.push_back(mk(1, 2'b11, 1, 1, 1, 2'b11, 0,  0, 2'b00, 2'b01, 1, 2'b01, 1));
    tbl.push_back(mk(0, 2'b11, 1, 0, 0, 2'b00, 0,  0, 2'b00, 2'b00, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 0, 2'b00, 0,  0, 2'b00, 2'b00, 0, 2'b00, 0));
    tbl.push_back(mk(1, 2'b01, 0, 0, 0, 2'b00, 0,  0, 2'b00, 2'b00, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 0,  0, 2'b01, 2'b00, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b00, 1, 0, 0, 2'b00, 0,  0, 2'b01, 2'b00, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 0, 0, 0, 2'b00, 0,  1, 2'b00, 2'b00, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 1, 0, 0, 2'b00, 0,  1, 2'b01, 2'b00, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 2'b01, 1,  0, 2'b00, 2'b01, 1, 2'b01, 1));
    tbl.push_back(mk(0, 2'b00, 0, 1, 0, 2'b00, 2,  0, 2'b00, 2'b01, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b00, 0, 1, 1, 2'b01, 3,  0, 2'b00, 2'b01, 1, 2'b01, 1));
    tbl.push_back(mk(0, 2'b11, 1, 0, 0, 2'b00, 0,  0, 2'b00, 2'b00, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 0, 2'b00, 0,  0, 2'b00, 2'b00, 0, 2'b00, 0));

    // Reset with fixed per-master payloads.
    rst_n = 1'b0;
    idle_inputs();
    m_bus.arid    = {4'h2, 4'h1};
    m_bus.araddr  = {32'h0000_0010, 32'h0000_0000};
    m_bus.arlen   = {8'd0, 8'd0};
    m_bus.arsize  = {3'd3, 3'd2};
    m_bus.arburst = {2'd2, 2'd1};
    #1;
    chk_all_zero("reset");
    chk("reset_state", arb_state, 2'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Table-driven section.
    for (int i = 0; i < tbl.size(); i++) begin
      enable        = tbl[i].en;
      m_bus.arvalid = tbl[i].arv;
      s_bus.arready = tbl[i].s_arr;
      s_bus.rvalid  = tbl[i].s_rv;
      s_bus.rlast   = tbl[i].s_rl;
      m_bus.rready  = tbl[i].m_rr;
      s_bus.rresp   = tbl[i].resp;
      #3;
      chk($sformatf("vec%0d_s_arvalid", i), s_bus.arvalid, tbl[i].e_s_arv);
      chk($sformatf("vec%0d_m_arready", i), m_bus.arready, tbl[i].e_arr);
      chk($sformatf("vec%0d_m_rvalid", i),  m_bus.rvalid,  tbl[i].e_rv);
      chk($sformatf("vec%0d_s_rready", i),  s_bus.rready,  tbl[i].e_s_rr);
      chk($sformatf("vec%0d_grant", i),     arb_grant,     tbl[i].e_grant);
      chk($sformatf("vec%0d_busy", i),      arb_busy,      tbl[i].e_busy);
      chk($sformatf("vec%0d_rresp", i),     m_bus.rresp,   tbl[i].resp);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // m0 alone, arlen 3, with beat 1 stalled for 5 cycles by m0 rready.
    do_read(0, 8'd3, 2'b00, 1, 5, 32'h0000_0000, 4'h1, 3'd2, 2'd1);
    next_cycle();

    // m1 alone, decode miss, arlen 2, DECERR on every beat.
    do_read(1, 8'd2, 2'b11, -1, 0, 32'h0000_0010, 4'h2, 3'd3, 2'd2);
    next_cycle();

    // m0 burst completes (last grant = m0), then a second m0 read is cut by reset.
    do_read(0, 8'd0, 2'b00, -1, 0, 32'h0000_0000, 4'h1, 3'd2, 2'd1);
    next_cycle();
    m_bus.arlen[7:0] = 8'd3;
    m_bus.arvalid = 2'b01;
    s_bus.arready = 1'b1;
    next_cycle();
    next_cycle();
    m_bus.arvalid = 2'b00;
    s_bus.arready = 1'b0;
    s_bus.rvalid  = 1'b1;
    m_bus.rready  = 2'b01;
    #3;
    chk("pre_rst_m_rvalid", m_bus.rvalid, 2'b01);
    chk("pre_rst_state", arb_state, 2'd2);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    chk("mid_rst_state", arb_state, 2'd0);
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    m_bus.arvalid = 2'b11;
    #3;
    chk("post_rst_busy", arb_busy, 1'b0);
    next_cycle();
    chk("post_rst_tie_grant", arb_grant, 2'b01);
    chk("post_rst_s_arvalid", s_bus.arvalid, 1'b1);
    chk("post_rst_araddr", s_bus.araddr, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
